des_crypt_pipeline: RTL and testbench
=====================================

Name: des_crypt_pipeline

Overview:
- Parametrised DES engine for the cipher datapath, with a configurable unroll factor and one register stage per group of rounds.
- Accepts one 64-bit block per cycle under valid/ready flow control; each block carries its own encrypt/decrypt mode and a sideband tag.
- Round keys are loaded once through a key-load handshake and held static.
- Sits between the key schedule, which supplies 16x48-bit subkeys, and the block-mode/DMA logic.

Parameters:
- ROUNDS_PER_STAGE, 4, DES rounds computed combinationally per pipeline stage; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
- STAGES, 16/ROUNDS_PER_STAGE, derived localparam; pipeline depth and latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside each block (legal 1..16).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_load  input  1  request to load round_keys.
- round_keys  input  768  K1..K16, K1 in bits [1:48], K16 in bits [721:768].
- key_ready  output  1  key load accepted this cycle when key_load && key_ready.
- in_valid  input  1  input block valid.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_decrypt  input  1  0 = encrypt, 1 = decrypt.
- in_block  input  64  plaintext or ciphertext, bit 1 = MSB.
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready.
- out_block  output  64  result after the inverse IP.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  at least one stage holds a valid block.

Behaviour:
- Reset, asynchronous, while rst_n = 0:
  - All stage valid bits are 0; out_valid = 0, busy = 0.
  - key_valid = 0 and the key register is 0; out_block/out_tag are driven 0.
  - in_ready = 0; key_ready = 1.
  - Reset mid-operation discards all in-flight blocks and the loaded key.
- Keys:
  - key_ready = !busy && !(in_valid && in_ready).
  - On a key handshake, round_keys are registered and key_valid is set to 1.
  - A key_load while busy is held off: key_ready = 0 and the request waits, never dropped silently by this block.
- Input:
  - in_ready = key_valid && !stall, where stall = out_valid && !out_ready.
  - On acceptance, the IP-permuted block enters stage 0 logic with its mode and tag.
- Stage s (0..STAGES-1):
  - Applies Feistel rounds r = s*ROUNDS_PER_STAGE+1 .. (s+1)*ROUNDS_PER_STAGE: L' = R, R' = L xor f(R, Kx).
  - Kx = K_r when encrypting, K_(17-r) when decrypting; selection is per block, from that block's registered mode bit.
  - Results are registered into stage s valid/L/R/mode/tag.
- Output:
  - After round 16, the halves are swapped (R16||L16) and the inverse IP is applied.
  - The inverse IP is combinational from the last stage register, so out_valid = last stage valid.
- Latency: exactly STAGES cycles from the input handshake to out_valid with no stall; throughput is 1 block/cycle.
- Flow control:
  - Global stall: when stall = 1, every stage register holds and no input is accepted.
  - Otherwise all stages shift by one; bubbles propagate as valid = 0.
  - Blocks stay in order; the tag/mode pairing is never reordered.
- Simultaneous events:
  - An input and an output handshake in the same cycle is legal and sustains full rate.
  - A key_load while in_valid && in_ready prioritises the block; the key waits for an idle cycle with the pipeline drained.
- busy = OR of all stage valid bits; it falls the cycle after the last result handshake.
- Hold guarantee: out_block/out_tag are stable while out_valid && !out_ready.
- Implementation constraint: the f-function is combinational (E expansion, S1..S8, P), reusing the codebase's permutation primitives; there is no start/done round handshake inside this block.

Test Plan:
- Load the subkeys of key 133457799BBCDFF1 (K1 = 1B02EFFC7072 ... K16 = CB3D8B0E17F5); send 0123456789ABCDEF, encrypt, tag 3 -> out_block 85E813540F0AB405, out_tag 3, exactly STAGES cycles after acceptance; repeat at ROUNDS_PER_STAGE = 1, 4, 16.
- Same key; send 85E813540F0AB405 with in_decrypt = 1 -> 0123456789ABCDEF. Also interleave encrypt/decrypt blocks back-to-back -> each result correct and in order with its tag.
- Key 0E329232EA6D0D73; stream 20 copies of 8787878787878787 with out_ready = 1 -> 20 outputs of 0000000000000000 on consecutive cycles, tags 0..19 mod 2^TAG_W.
- Random out_ready (50%) with continuous in_valid -> no block lost or duplicated; out_block stable while stalled; in_ready = 0 exactly when out_valid && !out_ready.
- key_load asserted while busy -> key_ready = 0 until the pipeline drains, then accepted; subsequent blocks use the new key. Before any key load, in_ready = 0.
- rst_n pulsed low asynchronously with 3 blocks in flight -> out_valid, busy and in_ready drop immediately with no clock edge; after release, no stale output appears and a key reload is required.

Source files
------------

// File: rtl/des_crypt_pipeline.sv
// Pipelined DES engine: ROUNDS_PER_STAGE Feistel rounds per register stage,
// per-block encrypt/decrypt mode and sideband tag, statically loaded subkeys.
module des_crypt_pipeline #(
  parameter int ROUNDS_PER_STAGE = 4,
  parameter int TAG_W            = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [767:0]     round_keys,
  output logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [63:0]      in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_block,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int STAGES = 16 / ROUNDS_PER_STAGE;

  if (!(ROUNDS_PER_STAGE == 1 || ROUNDS_PER_STAGE == 2 || ROUNDS_PER_STAGE == 4 ||
        ROUNDS_PER_STAGE == 8 || ROUNDS_PER_STAGE == 16)) begin : g_bad_rps
    $error("ROUNDS_PER_STAGE must be 1, 2, 4, 8 or 16");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("TAG_W must be in 1..16");
  end

  // Tables use DES bit numbering: entry value n means input bit n, bit 1 = MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
                               12,13,14,15,16,17, 16,17,18,19,20,21,
                               20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  // S-box entry index = {b1,b6,b2..b5}; entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) ip_perm[63-i] = x[64-IP_T[i]];
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    for (int i = 0; i < 64; i++) fp_perm[63-i] = x[64-FP_T[i]];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  c;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      c = x[47-6*i -: 6];
      s[31-4*i -: 4] = SBOX[i][255-4*int'({c[5], c[0], c[4:1]}) -: 4];
    end
    for (int i = 0; i < 32; i++) feistel[31-i] = s[32-P_T[i]];
  endfunction

  // K1 sits in the top 48 bits, K16 in the bottom 48.
  function automatic logic [47:0] subkey(input logic [767:0] keys, input int idx);
    subkey = keys[(16-idx)*48 +: 48];
  endfunction

  typedef struct packed {
    logic             dec;
    logic [TAG_W-1:0] tag;
    logic [31:0]      l;
    logic [31:0]      r;
  } stage_t;

  logic               key_valid;
  logic [767:0]       key_q;
  logic               stall;
  logic               acc;
  logic [STAGES-1:0]  vld;
  stage_t             head;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = key_valid && !stall;
  assign acc       = in_valid && in_ready;
  assign busy      = |vld;
  // Blocks win over key loads; a key only lands with the pipeline empty.
  assign key_ready = !busy && !acc;
  assign head      = {in_decrypt, in_tag, ip_perm(in_block)};

  // Key register: loaded once per handshake, held until the next load or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_q     <= '0;
    end else if (key_load && key_ready) begin
      key_valid <= 1'b1;
      key_q     <= round_keys;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    stage_t d_in, d, q;
    logic   v_in, v;

    if (s == 0) begin : g_head
      assign d_in = head;
      assign v_in = acc;
    end else begin : g_link
      assign d_in = g_st[s-1].q;
      assign v_in = g_st[s-1].v;
    end

    // This stage's rounds; subkey order follows the block's own mode bit.
    always_comb begin
      logic [31:0] lt, rt, tmp;
      int          rn;
      lt  = d_in.l;
      rt  = d_in.r;
      tmp = '0;
      rn  = 0;
      for (int k = 0; k < ROUNDS_PER_STAGE; k++) begin
        rn  = s*ROUNDS_PER_STAGE + k + 1;
        tmp = rt;
        rt  = lt ^ feistel(rt, subkey(key_q, d_in.dec ? 17 - rn : rn));
        lt  = tmp;
      end
      d   = d_in;
      d.l = lt;
      d.r = rt;
    end

    // Stage register: holds on global stall, otherwise shifts (bubbles included).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        q <= '0;
      end else if (!stall) begin
        v <= v_in;
        q <= d;
      end
    end

    assign vld[s] = v;
  end

  // Final swap R16||L16 then inverse IP, straight off the last register.
  assign out_valid = vld[STAGES-1];
  assign out_tag   = g_st[STAGES-1].q.tag;
  assign out_block = fp_perm({g_st[STAGES-1].q.r, g_st[STAGES-1].q.l});
endmodule

// File: tb/tb_des_crypt_pipeline.sv
// Directed bench for des_crypt_pipeline: known DES vectors, streaming,
// backpressure, key-load hold-off and asynchronous reset.
module tb_des_crypt_pipeline;
  localparam int RPS    = 4;
  localparam int TAG_W  = 4;
  localparam int STAGES = 16 / RPS;

  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                              10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                              16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                              44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_load = 1'b0;
  logic [767:0]     round_keys = '0;
  logic             key_ready;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_decrypt = 1'b0;
  logic [63:0]      in_block = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [63:0]      out_block;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  des_crypt_pipeline #(.ROUNDS_PER_STAGE(RPS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .round_keys(round_keys),
    .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
    .in_decrypt(in_decrypt), .in_block(in_block), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_tag(out_tag), .busy(busy));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference key schedule (PC1, rotations, PC2); K1 packed at the top.
  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    key_sched = '0;
    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < SH[r]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
      key_sched[(15-r)*48 +: 48] = k;
    end
  endfunction

  logic [63:0]      s_blk [$];
  bit               s_dec [$];
  logic [TAG_W-1:0] s_tag [$];
  logic [63:0]      s_exp [$];

  task automatic push(input logic [63:0] blk, input bit dec, input int tag, input logic [63:0] exp);
    s_blk.push_back(blk);
    s_dec.push_back(dec);
    s_tag.push_back(TAG_W'(tag));
    s_exp.push_back(exp);
  endtask

  task automatic load_key(input logic [767:0] ks);
    int cnt = 0;
    round_keys = ks;
    key_load   = 1'b1;
    #1;
    while (!key_ready && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    chk("key_ready_wait", key_ready, 1);
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Single block: checks acceptance, latency, result and tag, then drain.
  task automatic send_one(input logic [63:0] blk, input bit dec, input int tag, input logic [63:0] exp);
    int cnt;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_block   = blk;
    in_decrypt = dec;
    in_tag     = TAG_W'(tag);
    #1;
    chk("one_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("one_latency", cnt, STAGES);
    chk("one_block", out_block, exp);
    chk("one_tag", out_tag, TAG_W'(tag));
    @(posedge clk); #1;
    chk("one_busy_after", busy, 0);
  endtask

  // Streams the queued blocks, checking order, tags, stall hold and in_ready.
  task automatic stream(input bit rnd, output int first_c, output int last_c);
    int n = s_blk.size();
    int in_i = 0, out_i = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [63:0] pblk = '0;
    logic [TAG_W-1:0] ptag = '0;
    first_c = -1;
    last_c  = -1;
    while (out_i < n && cyc < 2000) begin
      in_valid = (in_i < n);
      if (in_i < n) begin
        in_block   = s_blk[in_i];
        in_decrypt = s_dec[in_i];
        in_tag     = s_tag[in_i];
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rnd) chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (stalled) begin
        chk("hold_block", out_block, pblk);
        chk("hold_tag", out_tag, ptag);
      end
      if (out_valid && out_ready) begin
        chk("stream_block", out_block, s_exp[out_i]);
        chk("stream_tag", out_tag, s_tag[out_i]);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        out_i++;
      end
      if (in_valid && in_ready) in_i++;
      stalled = out_valid && !out_ready;
      pblk    = out_block;
      ptag    = out_tag;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", out_i, n);
    s_blk.delete(); s_dec.delete(); s_tag.delete(); s_exp.delete();
  endtask

  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] PT2 = 64'h8787878787878787;

  initial begin
    logic [767:0] ks1, ks2;
    int first_c, last_c, outs, cnt;
    logic seen;

    ks1 = key_sched(64'h133457799BBCDFF1);
    ks2 = key_sched(64'h0E329232EA6D0D73);
    chk("ks_k1", ks1[767:720], 48'h1B02EFFC7072);
    chk("ks_k16", ks1[47:0], 48'hCB3D8B0E17F5);

    // Reset state, with a block offered while in reset.
    in_valid = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_out_block", out_block, 0);
    chk("rst_out_tag", out_tag, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("nokey_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Known-answer encrypt and decrypt.
    load_key(ks1);
    chk("key_in_ready", in_ready, 1);
    in_valid = 1'b1;
    #1;
    chk("key_ready_vs_block", key_ready, 0);
    in_valid = 1'b0;
    send_one(PT1, 1'b0, 3, CT1);
    send_one(CT1, 1'b1, 5, PT1);

    // Back-to-back interleaved modes.
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) push(PT1, 1'b0, 8 + i, CT1);
      else            push(CT1, 1'b1, 8 + i, PT1);
    stream(1'b0, first_c, last_c);

    // 20 blocks at full rate under the second key.
    load_key(ks2);
    for (int i = 0; i < 20; i++) push(PT2, 1'b0, i, 64'h0);
    stream(1'b0, first_c, last_c);
    chk("full_rate_span", last_c - first_c, 19);

    // Key load while busy must wait for drain; blocks in flight keep the old key.
    in_valid   = 1'b1;
    in_block   = PT2;
    in_decrypt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(i);
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    round_keys = ks1;
    key_load   = 1'b1;
    #1;
    chk("key_ready_busy", key_ready, 0);
    outs = 0;
    cnt  = 0;
    while (!key_ready && cnt < 100) begin
      if (out_valid) begin
        chk("busy_block", out_block, 64'h0);
        chk("busy_tag", out_tag, TAG_W'(outs));
        outs++;
      end
      @(posedge clk); #1;
      cnt++;
    end
    chk("busy_outs", outs, 3);
    chk("busy_drained", busy, 0);
    @(posedge clk); #1;
    key_load = 1'b0;

    // Random backpressure with continuous input, new key in use.
    for (int i = 0; i < 30; i++)
      if (i % 3 == 2) push(CT1, 1'b1, i, PT1);
      else            push(PT1, 1'b0, i, CT1);
    stream(1'b1, first_c, last_c);

    // Asynchronous reset with blocks in flight and output stalled.
    in_valid   = 1'b1;
    in_block   = PT1;
    in_decrypt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_tag = TAG_W'(i);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_block", out_block, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("no_stale_output", seen, 0);
    chk("reload_required", in_ready, 0);
    load_key(ks1);
    send_one(PT1, 1'b0, 7, CT1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
